// File: rtl/uart_cfg_master_if.sv
// Host request/response channel and uart_top configuration bus of uart_cfg_master.
// The slave modport is the block's view; master is the surrounding environment.
interface uart_cfg_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_data_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        busy_o;
    logic        cfg_cs_o;
    logic        cfg_we_o;
    logic [4:0]  cfg_addr_o;
    logic [31:0] cfg_wdata_o;
    logic [31:0] cfg_rdata_i;
    logic        tx_int_i;
    logic        err_int_i;

    modport slave (
        input  req_valid_i, req_op_i, req_addr_i, req_data_i, cfg_rdata_i, tx_int_i, err_int_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
        output cfg_cs_o, cfg_we_o, cfg_addr_o, cfg_wdata_o
    );

    modport master (
        output req_valid_i, req_op_i, req_addr_i, req_data_i, cfg_rdata_i, tx_int_i, err_int_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o,
        input  cfg_cs_o, cfg_we_o, cfg_addr_o, cfg_wdata_o
    );
endinterface

// File: rtl/uart_cfg_master.sv
// Turns host byte-level requests into uart_top cfg register transactions:
// write, read, init (divider + enables) and send-byte with tx_int wait.
module uart_cfg_master #(
    parameter logic [15:0] DIV_DEFAULT    = 16'd10416,
    parameter int          TIMEOUT_CYCLES = 600000,
    parameter int          TIMEOUT_W      = 20
) (
    input logic               clk,
    input logic               rst_i,
    uart_cfg_master_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, SB_DATA, SB_CMD, SB_WAIT, RESP} state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_SEND  = 2'b10;
    localparam logic [1:0] OP_INIT  = 2'b11;
    localparam logic [4:0] ADDR_CTRL   = 5'd0;
    localparam logic [4:0] ADDR_CMD    = 5'd1;
    localparam logic [4:0] ADDR_TXDATA = 5'd2;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t                state;
    logic [TIMEOUT_W-1:0]  cnt;
    logic                  ready, busy, rsp_valid, rsp_err;
    logic [31:0]           rsp_data;
    logic                  cs, we;
    logic [4:0]            addr;
    logic [31:0]           wdata;
    logic [15:0]           init_div;

    assign init_div = (bus.req_data_i[15:0] == 16'd0) ? DIV_DEFAULT : bus.req_data_i[15:0];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b0;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cs        <= 1'b0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (bus.req_valid_i && ready) begin
                        // Strobe is registered here so it shows up the cycle after accept.
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        cs    <= 1'b1;
                        case (bus.req_op_i)
                            OP_WRITE: begin
                                we    <= 1'b1;
                                addr  <= bus.req_addr_i;
                                wdata <= bus.req_data_i;
                                state <= WR;
                            end
                            OP_READ: begin
                                we    <= 1'b0;
                                addr  <= bus.req_addr_i;
                                wdata <= '0;
                                state <= RD;
                            end
                            OP_SEND: begin
                                we    <= 1'b1;
                                addr  <= ADDR_TXDATA;
                                wdata <= {24'd0, bus.req_data_i[7:0]};
                                state <= SB_DATA;
                            end
                            default: begin
                                we    <= 1'b1;
                                addr  <= ADDR_CTRL;
                                wdata <= {init_div, 13'd0, 3'b111};
                                state <= WR;
                            end
                        endcase
                    end
                end
                WR: begin
                    cs        <= 1'b0;
                    we        <= 1'b0;
                    addr      <= '0;
                    wdata     <= '0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    state     <= RESP;
                end
                RD: begin
                    cs    <= 1'b0;
                    addr  <= '0;
                    state <= RD_CAP;
                end
                RD_CAP: begin
                    rsp_data  <= bus.cfg_rdata_i;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                SB_DATA: begin
                    addr  <= ADDR_CMD;
                    wdata <= 32'h1;
                    state <= SB_CMD;
                end
                SB_CMD: begin
                    cs    <= 1'b0;
                    we    <= 1'b0;
                    addr  <= '0;
                    wdata <= '0;
                    cnt   <= '0;
                    state <= SB_WAIT;
                end
                SB_WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Error or timeout outranks a coincident tx_int.
                    if (bus.err_int_i || cnt == CNT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end else if (bus.tx_int_i) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    ready     <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.busy_o      = busy;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_err_o   = rsp_err;
    assign bus.rsp_data_o  = rsp_data;
    assign bus.cfg_cs_o    = cs;
    assign bus.cfg_we_o    = we;
    assign bus.cfg_addr_o  = addr;
    assign bus.cfg_wdata_o = wdata;
endmodule

// File: tb/tb_uart_cfg_master.sv
// Directed bench for uart_cfg_master: reset, init, write/read, send-byte,
// timeout, error interrupt and reset during the tx wait.
module tb_uart_cfg_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    uart_cfg_master_if u_if();

    uart_cfg_master #(
        .DIV_DEFAULT(16'd10416),
        .TIMEOUT_CYCLES(100),
        .TIMEOUT_W(8)
    ) dut (
        .clk(clk),
        .rst_i(rst),
        .bus(u_if.slave)
    );

    // Register file stand-in for uart_top: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (u_if.cfg_cs_o && u_if.cfg_we_o) mem[u_if.cfg_addr_o] <= u_if.cfg_wdata_o;
        if (u_if.cfg_cs_o && !u_if.cfg_we_o) u_if.cfg_rdata_i <= mem[u_if.cfg_addr_o];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        u_if.req_valid_i = 1'b1;
        u_if.req_op_i    = op;
        u_if.req_addr_i  = a;
        u_if.req_data_i  = d;
        @(negedge clk);
        u_if.req_valid_i = 1'b0;
        u_if.req_op_i    = 2'b00;
        u_if.req_addr_i  = '0;
        u_if.req_data_i  = '0;
    endtask

    task automatic test_reset;
        logic [5:0] flags;
        repeat (5) @(negedge clk);
        flags = {u_if.req_ready_o, u_if.busy_o, u_if.rsp_valid_o, u_if.rsp_err_o, u_if.cfg_cs_o, u_if.cfg_we_o};
        n_cmp++; if (flags !== 6'b0) begin n_bad++; $display("FAIL reset_flags got %b want 000000", flags); end
        n_cmp++; if ({u_if.rsp_data_o, u_if.cfg_wdata_o, u_if.cfg_addr_o} !== 69'd0) begin n_bad++; $display("FAIL reset_data got %h/%h/%h want 0", u_if.rsp_data_o, u_if.cfg_wdata_o, u_if.cfg_addr_o); end
        rst = 1'b0;
        @(negedge clk);
        flags = {u_if.req_ready_o, u_if.busy_o, u_if.rsp_valid_o, u_if.rsp_err_o, u_if.cfg_cs_o, u_if.cfg_we_o};
        n_cmp++; if (flags !== 6'b100000) begin n_bad++; $display("FAIL post_reset_flags got %b want 100000", flags); end
    endtask

    task automatic test_init;
        logic [38:0] strobe;
        n_cmp++; if (u_if.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL init_ready got %b want 1", u_if.req_ready_o); end
        issue(2'b11, 5'd9, 32'h0);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'd0, 32'h28B00007}) begin n_bad++; $display("FAIL init_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'd0, 32'h28B00007}); end
        n_cmp++; if ({u_if.req_ready_o, u_if.busy_o, u_if.rsp_valid_o} !== 3'b010) begin n_bad++; $display("FAIL init_busy got %b want 010", {u_if.req_ready_o, u_if.busy_o, u_if.rsp_valid_o}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.cfg_cs_o} !== 3'b100) begin n_bad++; $display("FAIL init_rsp got %b want 100", {u_if.rsp_valid_o, u_if.rsp_err_o, u_if.cfg_cs_o}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.req_ready_o, u_if.busy_o} !== 3'b010) begin n_bad++; $display("FAIL init_idle got %b want 010", {u_if.rsp_valid_o, u_if.req_ready_o, u_if.busy_o}); end
        // Non-zero divider overrides the default; upper request bits ignored.
        issue(2'b11, 5'd0, 32'h1234000A);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'd0, 32'h000A0007}) begin n_bad++; $display("FAIL init_div_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'd0, 32'h000A0007}); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_read;
        logic [38:0] strobe;
        issue(2'b00, 5'd2, 32'h55);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'd2, 32'h55}) begin n_bad++; $display("FAIL wr_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'd2, 32'h55}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o} !== 2'b10) begin n_bad++; $display("FAIL wr_rsp got %b want 10", {u_if.rsp_valid_o, u_if.rsp_err_o}); end
        @(negedge clk);
        issue(2'b01, 5'd2, 32'hFFFFFFFF);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b0, 5'd2, 32'h0}) begin n_bad++; $display("FAIL rd_strobe got %h want %h", strobe, {1'b1, 1'b0, 5'd2, 32'h0}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.cfg_cs_o} !== 2'b00) begin n_bad++; $display("FAIL rd_cap got %b want 00", {u_if.rsp_valid_o, u_if.cfg_cs_o}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_data_o} !== {1'b1, 1'b0, 32'h55}) begin n_bad++; $display("FAIL rd_rsp got %b/%b/%h want 1/0/00000055", u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_data_o); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.req_ready_o, u_if.rsp_data_o} !== {1'b0, 1'b1, 32'h55}) begin n_bad++; $display("FAIL rd_hold got %b/%b/%h want 0/1/00000055", u_if.rsp_valid_o, u_if.req_ready_o, u_if.rsp_data_o); end
    endtask

    task automatic test_send_byte;
        logic [38:0] strobe;
        issue(2'b10, 5'd7, 32'hFFFFFFA5);
        u_if.tx_int_i = 1'b1;
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'd2, 32'hA5}) begin n_bad++; $display("FAIL sb_data_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'd2, 32'hA5}); end
        @(negedge clk);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'd1, 32'h1}) begin n_bad++; $display("FAIL sb_cmd_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'd1, 32'h1}); end
        @(negedge clk);
        u_if.tx_int_i = 1'b0;
        n_cmp++; if ({u_if.cfg_cs_o, u_if.rsp_valid_o, u_if.busy_o} !== 3'b001) begin n_bad++; $display("FAIL sb_early_tx_ignored got %b want 001", {u_if.cfg_cs_o, u_if.rsp_valid_o, u_if.busy_o}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (u_if.rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL sb_wait_%0d got %b want 0", i, u_if.rsp_valid_o); end
        end
        u_if.tx_int_i = 1'b1;
        @(negedge clk);
        u_if.tx_int_i = 1'b0;
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_data_o} !== {1'b1, 1'b0, 32'h0}) begin n_bad++; $display("FAIL sb_rsp got %b/%b/%h want 1/0/00000000", u_if.rsp_valid_o, u_if.rsp_err_o, u_if.rsp_data_o); end
        @(negedge clk);
        n_cmp++; if (u_if.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL sb_ready got %b want 1", u_if.req_ready_o); end
    endtask

    task automatic test_timeout;
        int lat;
        logic err;
        lat = -1;
        err = 1'b0;
        issue(2'b10, 5'd0, 32'h3C);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 200; i++) begin
            if (u_if.rsp_valid_o) begin lat = i; err = u_if.rsp_err_o; break; end
            @(negedge clk);
        end
        n_cmp++; if (lat != 100) begin n_bad++; $display("FAIL timeout_latency got %0d want 100", lat); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b want 1", err); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.req_ready_o} !== 2'b01) begin n_bad++; $display("FAIL timeout_idle got %b want 01", {u_if.rsp_valid_o, u_if.req_ready_o}); end
    endtask

    task automatic test_err_int;
        issue(2'b10, 5'd0, 32'h11);
        repeat (2) @(negedge clk);
        repeat (10) @(negedge clk);
        n_cmp++; if (u_if.rsp_valid_o !== 1'b0) begin n_bad++; $display("FAIL errint_pre got %b want 0", u_if.rsp_valid_o); end
        u_if.err_int_i = 1'b1;
        @(negedge clk);
        u_if.err_int_i = 1'b0;
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o} !== 2'b11) begin n_bad++; $display("FAIL errint_rsp got %b want 11", {u_if.rsp_valid_o, u_if.rsp_err_o}); end
        @(negedge clk);
        // tx_int and err_int together: error wins.
        issue(2'b10, 5'd0, 32'h22);
        repeat (4) @(negedge clk);
        u_if.err_int_i = 1'b1;
        u_if.tx_int_i  = 1'b1;
        @(negedge clk);
        u_if.err_int_i = 1'b0;
        u_if.tx_int_i  = 1'b0;
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o} !== 2'b11) begin n_bad++; $display("FAIL both_int_rsp got %b want 11", {u_if.rsp_valid_o, u_if.rsp_err_o}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [38:0] strobe;
        logic seen;
        seen = 1'b0;
        issue(2'b10, 5'd0, 32'h77);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if ({u_if.busy_o, u_if.cfg_cs_o, u_if.cfg_we_o, u_if.rsp_valid_o, u_if.req_ready_o} !== 5'b0) begin n_bad++; $display("FAIL midrst_flags got %b want 00000", {u_if.busy_o, u_if.cfg_cs_o, u_if.cfg_we_o, u_if.rsp_valid_o, u_if.req_ready_o}); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (u_if.rsp_valid_o) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_rsp got %b want 0", seen); end
        n_cmp++; if ({u_if.req_ready_o, u_if.busy_o} !== 2'b10) begin n_bad++; $display("FAIL midrst_idle got %b want 10", {u_if.req_ready_o, u_if.busy_o}); end
        issue(2'b00, 5'h1F, 32'hDEADBEEF);
        strobe = {u_if.cfg_cs_o, u_if.cfg_we_o, u_if.cfg_addr_o, u_if.cfg_wdata_o};
        n_cmp++; if (strobe !== {1'b1, 1'b1, 5'h1F, 32'hDEADBEEF}) begin n_bad++; $display("FAIL midrst_wr_strobe got %h want %h", strobe, {1'b1, 1'b1, 5'h1F, 32'hDEADBEEF}); end
        @(negedge clk);
        n_cmp++; if ({u_if.rsp_valid_o, u_if.rsp_err_o} !== 2'b10) begin n_bad++; $display("FAIL midrst_wr_rsp got %b want 10", {u_if.rsp_valid_o, u_if.rsp_err_o}); end
        @(negedge clk);
    endtask

    initial begin
        u_if.req_valid_i = 1'b0;
        u_if.req_op_i    = 2'b00;
        u_if.req_addr_i  = '0;
        u_if.req_data_i  = '0;
        u_if.tx_int_i    = 1'b0;
        u_if.err_int_i   = 1'b0;
        test_reset;
        test_init;
        test_write_read;
        test_send_byte;
        test_timeout;
        test_err_int;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
